// File: rtl/dual_issue_scheduler_pkg.sv
// ISA constants and decode helpers shared by the scheduler and the decode hazard unit.
package dual_issue_scheduler_pkg;

    localparam int unsigned ISA_W = 32;
    localparam int unsigned REG_W = 5;

    // Instruction field positions
    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 27;
    localparam int unsigned RD_HI  = 26;
    localparam int unsigned RD_LO  = 22;
    localparam int unsigned RS_HI  = 21;
    localparam int unsigned RS_LO  = 17;
    localparam int unsigned RT_HI  = 16;
    localparam int unsigned RT_LO  = 12;

    localparam logic [REG_W-1:0] REG_R0  = 5'd0;
    localparam logic [REG_W-1:0] REG_R30 = 5'd30;
    localparam logic [REG_W-1:0] REG_R31 = 5'd31;

    typedef enum logic [4:0] {
        OpR    = 5'b00000,
        OpJ    = 5'b00001,
        OpBne  = 5'b00010,
        OpJal  = 5'b00011,
        OpJr   = 5'b00100,
        OpAddi = 5'b00101,
        OpBlt  = 5'b00110,
        OpSw   = 5'b00111,
        OpLw   = 5'b01000,
        OpSetx = 5'b10101,
        OpBex  = 5'b10110
    } opcode_e;

    function automatic opcode_e opcode_of(input logic [ISA_W-1:0] insn);
        return opcode_e'(insn[OPC_HI:OPC_LO]);
    endfunction

    // Destination register; r0 means the insn writes nothing.
    function automatic logic [REG_W-1:0] dest_of(input logic [ISA_W-1:0] insn);
        case (opcode_of(insn))
            OpR, OpAddi, OpLw: return insn[RD_HI:RD_LO];
            OpJal:             return REG_R31;
            OpSetx:            return REG_R30;
            default:           return REG_R0;
        endcase
    endfunction

    function automatic logic is_control(input opcode_e opc);
        return (opc == OpJ) || (opc == OpBne) || (opc == OpJal) || (opc == OpJr) ||
               (opc == OpBlt) || (opc == OpBex);
    endfunction

    function automatic logic is_mem(input opcode_e opc);
        return (opc == OpLw) || (opc == OpSw);
    endfunction

endpackage

// File: rtl/dual_issue_scheduler_if.sv
// Fetch-side and issue-side signals of the dual-issue scheduler.
interface dual_issue_scheduler_if #(
    parameter int unsigned PC_W   = 12,
    parameter int unsigned INSN_W = 32
);
    logic              fetch_valid;
    logic [PC_W-1:0]   fetch_pc;
    logic [INSN_W-1:0] fetch_insn_a;
    logic [INSN_W-1:0] fetch_insn_b;
    logic              fetch_ready;
    logic              stall;
    logic              flush;
    logic              issue_valid_a;
    logic [INSN_W-1:0] issue_insn_a;
    logic [PC_W-1:0]   issue_pc_a;
    logic              issue_valid_b;
    logic [INSN_W-1:0] issue_insn_b;
    logic [PC_W-1:0]   issue_pc_b;
    logic [2:0]        occupancy;

    // Environment side: fetch unit and DX stage
    modport master (
        output fetch_valid, fetch_pc, fetch_insn_a, fetch_insn_b, stall, flush,
        input  fetch_ready, issue_valid_a, issue_insn_a, issue_pc_a,
        input  issue_valid_b, issue_insn_b, issue_pc_b, occupancy
    );

    // Scheduler side
    modport slave (
        input  fetch_valid, fetch_pc, fetch_insn_a, fetch_insn_b, stall, flush,
        output fetch_ready, issue_valid_a, issue_insn_a, issue_pc_a,
        output issue_valid_b, issue_insn_b, issue_pc_b, occupancy
    );
endinterface

// File: rtl/dual_issue_scheduler_pair_hazard_check.sv
// Decides whether the younger insn may issue alongside the older one in the same cycle.
module dual_issue_scheduler_pair_hazard_check
    import dual_issue_scheduler_pkg::*;
(
    input  logic [ISA_W-1:0] i_insn_a,
    input  logic [ISA_W-1:0] i_insn_b,
    output logic             o_pair_ok
);
    opcode_e          w_opc_a;
    opcode_e          w_opc_b;
    logic [REG_W-1:0] w_dest_a;
    logic [REG_W-1:0] w_dest_b;
    logic [REG_W-1:0] w_src0_b;
    logic [REG_W-1:0] w_src1_b;
    logic             w_raw;
    logic             w_waw;
    logic             w_mem;
    logic             w_unused_bits;

    assign w_opc_a  = opcode_of(i_insn_a);
    assign w_opc_b  = opcode_of(i_insn_b);
    assign w_dest_a = dest_of(i_insn_a);
    assign w_dest_b = dest_of(i_insn_b);

    // Registers read by B; r0 stands for "no source" and never matches a real dest.
    always_comb begin
        w_src0_b = REG_R0;
        w_src1_b = REG_R0;
        case (w_opc_b)
            OpR: begin
                w_src0_b = i_insn_b[RS_HI:RS_LO];
                w_src1_b = i_insn_b[RT_HI:RT_LO];
            end
            OpAddi, OpLw: w_src0_b = i_insn_b[RS_HI:RS_LO];
            OpSw, OpBne, OpBlt: begin
                w_src0_b = i_insn_b[RD_HI:RD_LO];
                w_src1_b = i_insn_b[RS_HI:RS_LO];
            end
            OpJr:    w_src0_b = i_insn_b[RD_HI:RD_LO];
            OpBex:   w_src0_b = REG_R30;
            default: ;
        endcase
    end

    assign w_raw = (w_dest_a != REG_R0) && ((w_src0_b == w_dest_a) || (w_src1_b == w_dest_a));
    assign w_waw = (w_dest_a != REG_R0) && (w_dest_a == w_dest_b);
    // One shared dmem address per pair
    assign w_mem = is_mem(w_opc_a) && is_mem(w_opc_b);

    assign o_pair_ok = !(is_control(w_opc_a) || w_raw || w_waw || w_mem);

    assign w_unused_bits = ^{i_insn_a[RS_HI:0], i_insn_b[RT_LO-1:0]};

endmodule

// File: rtl/dual_issue_scheduler.sv
// Circular insn buffer between 2-wide fetch and decode, issuing 0/1/2 insns per cycle.
module dual_issue_scheduler
    import dual_issue_scheduler_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned PC_W      = 12,
    parameter int unsigned INSN_W    = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    dual_issue_scheduler_if.slave io_bus
);
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    logic [INSN_W-1:0] r_insn [BUF_DEPTH];
    logic [PC_W-1:0]   r_pc   [BUF_DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [PTR_W-1:0]  w_rd_ptr_next;
    logic [PTR_W-1:0]  w_wr_ptr_next;
    logic [CNT_W-1:0]  w_count_next;
    logic [PTR_W-1:0]  w_rd_ptr_b;
    logic [PTR_W-1:0]  w_wr_ptr_b;
    logic              w_fetch_ready;
    logic              w_push;
    logic              w_issue_a;
    logic              w_issue_b;
    logic              w_pair_ok;
    logic [1:0]        w_pops;

    assign w_fetch_ready = (r_count <= CNT_W'(BUF_DEPTH - 2));
    assign w_push        = io_bus.fetch_valid && w_fetch_ready && !io_bus.flush;
    assign w_rd_ptr_b    = r_rd_ptr + PTR_W'(1);
    assign w_wr_ptr_b    = r_wr_ptr + PTR_W'(1);

    dual_issue_scheduler_pair_hazard_check u_pair_check (
        .i_insn_a  (r_insn[r_rd_ptr]),
        .i_insn_b  (r_insn[w_rd_ptr_b]),
        .o_pair_ok (w_pair_ok)
    );

    assign w_issue_a = (r_count != '0) && !io_bus.stall && !io_bus.flush;
    assign w_issue_b = w_issue_a && (r_count >= CNT_W'(2)) && w_pair_ok;
    assign w_pops    = {1'b0, w_issue_a} + {1'b0, w_issue_b};

    assign io_bus.fetch_ready   = w_fetch_ready;
    assign io_bus.issue_valid_a = w_issue_a;
    assign io_bus.issue_insn_a  = r_insn[r_rd_ptr];
    assign io_bus.issue_pc_a    = r_pc[r_rd_ptr];
    assign io_bus.issue_valid_b = w_issue_b;
    assign io_bus.issue_insn_b  = r_insn[w_rd_ptr_b];
    assign io_bus.issue_pc_b    = r_pc[w_rd_ptr_b];
    assign io_bus.occupancy     = 3'(r_count);

    // Pointer/count next state; flush empties the buffer and overrides push and pop.
    always_comb begin
        w_rd_ptr_next = r_rd_ptr + PTR_W'(w_pops);
        w_wr_ptr_next = w_push ? (r_wr_ptr + PTR_W'(2)) : r_wr_ptr;
        w_count_next  = r_count + (w_push ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(w_pops);
        if (io_bus.flush) begin
            w_rd_ptr_next = '0;
            w_wr_ptr_next = '0;
            w_count_next  = '0;
        end
    end

    // Pointer and count registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_next;
            r_wr_ptr <= w_wr_ptr_next;
            r_count  <= w_count_next;
        end
    end

    // Entry storage; contents need no reset since count gates their use.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_insn[r_wr_ptr]   <= io_bus.fetch_insn_a;
            r_pc[r_wr_ptr]     <= io_bus.fetch_pc;
            r_insn[w_wr_ptr_b] <= io_bus.fetch_insn_b;
            r_pc[w_wr_ptr_b]   <= io_bus.fetch_pc + PC_W'(1);
        end
    end

endmodule
